// File: rtl/calc_pkg.sv
// Shared op codes, FSM state encoding and a dispatch helper for the sequential calculator.
package calc_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Only mul and a divide with a usable divisor need the iterative core.
  function automatic logic needs_run(input op_e op, input logic b_is_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_is_zero);
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// 2W-bit accumulator and one (W+2)-bit adder/subtractor.
module seq_muldiv_core #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           is_div,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] res
);

  localparam int unsigned RW = 2 * W;

  logic [RW-1:0] r_acc;
  logic [W-1:0]  r_m;

  logic [W-1:0]  w_hi;
  logic [W-1:0]  w_lo;
  logic [W:0]    w_trial;
  logic [W+1:0]  w_x;
  logic [W+1:0]  w_y;
  logic [W+1:0]  w_as;
  logic          w_ge;
  logic [RW-1:0] w_acc_nxt;

  // Mul: high half accumulates, whole register shifts right.
  // Div: {rem, quo} shifts left, trial subtract decides the quotient bit.
  always_comb begin
    w_hi      = r_acc[RW-1:W];
    w_lo      = r_acc[W-1:0];
    w_trial   = {w_hi, w_lo[W-1]};
    w_x       = is_div ? {1'b0, w_trial} : {2'b00, w_hi};
    w_y       = {2'b00, r_m};
    w_as      = is_div ? (w_x - w_y) : (w_x + w_y);
    w_ge      = ~w_as[W+1];
    w_acc_nxt = r_acc;
    if (is_div) begin
      if (w_ge) begin
        w_acc_nxt = {w_as[W-1:0], w_lo[W-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_trial[W-1:0], w_lo[W-2:0], 1'b0};
      end
    end else if (w_lo[0]) begin
      w_acc_nxt = {w_as[W:0], w_lo[W-1:1]};
    end else begin
      w_acc_nxt = {1'b0, w_hi, w_lo[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_m   <= '0;
    end else if (load) begin
      r_acc <= {{W{1'b0}}, a};
      r_m   <= b;
    end else if (step) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign res = r_acc;

endmodule

// File: rtl/seq_calc.sv
// Clocked W-bit calculator: single-cycle add/sub, iterative mul/div, with a
// start/busy/done handshake and registered result and flags.
module seq_calc
  import calc_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     op_sel,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           cout,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int unsigned RW    = 2 * W;
  localparam int unsigned CNT_W = $clog2(W) + 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  op_e              r_op;

  logic             w_accept;
  logic             w_load;
  logic             w_step;
  logic [RW-1:0]    w_core_res;

  logic [W:0]       w_as;
  logic             w_as_ovf;
  logic [RW-1:0]    w_res_nxt;
  logic             w_cout_nxt;
  logic             w_ovf_nxt;
  logic             w_dbz_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (needs_run(op_e'(op_sel), b == '0)) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = CNT_W'(W);
            w_load      = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      RUN: begin
        w_step    = 1'b1;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands are frozen at acceptance so front-end changes cannot disturb a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= OP_ADD;
    end else if (w_accept) begin
      r_a  <= a;
      r_b  <= b;
      r_op <= op_e'(op_sel);
    end
  end

  seq_muldiv_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .is_div (r_op == OP_DIV),
    .step   (w_step),
    .a      (a),
    .b      (b),
    .res    (w_core_res)
  );

  always_comb begin
    if (r_op == OP_SUB) begin
      w_as     = {1'b0, r_a} + {1'b0, ~r_b} + (W+1)'(1);
      w_as_ovf = (r_a[W-1] != r_b[W-1]) && (w_as[W-1] != r_a[W-1]);
    end else begin
      w_as     = {1'b0, r_a} + {1'b0, r_b};
      w_as_ovf = (r_a[W-1] == r_b[W-1]) && (w_as[W-1] != r_a[W-1]);
    end
  end

  always_comb begin
    w_res_nxt  = '0;
    w_cout_nxt = 1'b0;
    w_ovf_nxt  = 1'b0;
    w_dbz_nxt  = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res_nxt  = RW'(w_as);
        w_cout_nxt = w_as[W];
        w_ovf_nxt  = w_as_ovf;
      end
      OP_MUL: w_res_nxt = w_core_res;
      OP_DIV: begin
        if (r_b == '0) begin
          w_res_nxt = {r_a, {W{1'b1}}};
          w_dbz_nxt = 1'b1;
        end else begin
          w_res_nxt = w_core_res;
        end
      end
      default: w_res_nxt = '0;
    endcase
  end

  // done/busy lag the FSM by one edge; results land together with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      cout        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (r_state == RUN);
      done <= (r_state == DONE);
      if (r_state == DONE) begin
        result      <= w_res_nxt;
        cout        <= w_cout_nxt;
        overflow    <= w_ovf_nxt;
        div_by_zero <= w_dbz_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_calc.sv
// Self-checking bench for seq_calc: directed table, randomized ops against an
// arithmetic reference model, and handshake/reset corner sequences.
module tb_seq_calc;
  import calc_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op_sel;
  logic          start;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          cout;
  logic          overflow;
  logic          div_by_zero;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          cout;
    logic          ovf;
    logic          dbz;
  } exp_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic [RW-1:0] res;
    logic          cout;
    logic          ovf;
    logic          dbz;
    int            lat;
  } vec_t;

  seq_calc #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .op_sel      (op_sel),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference computed from plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [1:0] mop);
    exp_t e;
    int ia, ib, sa, sb, s, lim, mask;
    ia   = int'(ma);
    ib   = int'(mb);
    sa   = ma[W-1] ? ia - (1 << W) : ia;
    sb   = mb[W-1] ? ib - (1 << W) : ib;
    lim  = 1 << (W - 1);
    mask = (1 << W) - 1;
    e    = '0;
    case (mop)
      2'd0: begin
        s      = ia + ib;
        e.res  = RW'(s);
        e.cout = (s > mask);
        s      = sa + sb;
        e.ovf  = (s >= lim) || (s < -lim);
      end
      2'd1: begin
        e.cout = (ia >= ib);
        e.res  = RW'((int'(e.cout) << W) | ((ia - ib) & mask));
        s      = sa - sb;
        e.ovf  = (s >= lim) || (s < -lim);
      end
      2'd2: e.res = RW'(ia * ib);
      default: begin
        if (ib == 0) begin
          e.res = RW'((ia << W) | mask);
          e.dbz = 1'b1;
        end else begin
          e.res = RW'(((ia % ib) << W) | (ia / ib));
        end
      end
    endcase
    return e;
  endfunction

  function automatic int model_lat(input logic [W-1:0] mb, input logic [1:0] mop);
    if (mop == 2'd2 || (mop == 2'd3 && mb != '0)) return W + 1;
    return 1;
  endfunction

  // Issue one op, scramble inputs after acceptance, count edges until done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top,
                        output int lat, output int bc);
    @(negedge clk);
    a = ta; b = tb; op_sel = top; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op_sel = 2'($urandom);
    lat = 0;
    bc  = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
      if (busy) bc++;
    end
  endtask

  task automatic check_out(input string nm, input exp_t e, input int el, input int lat, input int bc);
    chk({nm, " latency"}, 32'(lat), 32'(el));
    chk({nm, " result"}, 32'(result), 32'(e.res));
    chk({nm, " cout"}, 32'(cout), 32'(e.cout));
    chk({nm, " overflow"}, 32'(overflow), 32'(e.ovf));
    chk({nm, " div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
    chk({nm, " busy cycles"}, 32'(bc), 32'(el - 1));
    chk({nm, " busy in done cycle"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({nm, " done pulse width"}, 32'(done), 32'd0);
    chk({nm, " result hold"}, 32'(result), 32'(e.res));
  endtask

  vec_t vecs[8];

  initial begin
    int   lat, bc, n_done, nd;
    int   tms[8];
    exp_t e;
    logic [W-1:0] ta, tb;
    logic [1:0]   top;

    vecs[0] = '{4'd9,  4'd8,  OP_ADD, 8'h11, 1'b1, 1'b1, 1'b0, 1};
    vecs[1] = '{4'd7,  4'd8,  OP_SUB, 8'h0F, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{4'd3,  4'd5,  OP_SUB, 8'h0E, 1'b0, 1'b0, 1'b0, 1};
    vecs[3] = '{4'd15, 4'd15, OP_MUL, 8'hE1, 1'b0, 1'b0, 1'b0, 5};
    vecs[4] = '{4'd13, 4'd4,  OP_DIV, 8'h13, 1'b0, 1'b0, 1'b0, 5};
    vecs[5] = '{4'd9,  4'd0,  OP_DIV, 8'h9F, 1'b0, 1'b0, 1'b1, 1};
    vecs[6] = '{4'd5,  4'd3,  OP_SUB, 8'h12, 1'b1, 1'b0, 1'b0, 1};
    vecs[7] = '{4'd15, 4'd1,  OP_ADD, 8'h10, 1'b1, 1'b0, 1'b0, 1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; op_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      e.res = vecs[i].res; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf; e.dbz = vecs[i].dbz;
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat, bc);
      check_out($sformatf("vec%0d", i), e, vecs[i].lat, lat, bc);
    end

    for (int i = 0; i < 40; i++) begin
      ta  = W'($urandom);
      tb  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      top = 2'($urandom);
      e   = model(ta, tb, top);
      run_op(ta, tb, top, lat, bc);
      check_out($sformatf("rnd%0d", i), e, model_lat(tb, top), lat, bc);
    end

    // start pulses during RUN must be ignored
    @(negedge clk);
    a = 4'd3; b = 4'd5; op_sel = OP_MUL; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (i == 1 || i == 2) begin
        start = 1'b1; op_sel = OP_ADD; a = 4'd1; b = 4'd1;
      end else begin
        start = 1'b0;
      end
    end
    chk("ignored start done count", 32'(n_done), 32'd1);
    chk("ignored start result", 32'(result), 32'h0F);

    // start held high: back-to-back muls, W+2 cycles apart
    @(negedge clk);
    a = 4'd2; b = 4'd3; op_sel = OP_MUL; start = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (nd < 8) tms[nd] = i;
        nd++;
        chk($sformatf("held start result %0d", nd), 32'(result), 32'h06);
      end
    end
    start = 1'b0;
    chk("held start done count", 32'(nd >= 3), 32'd1);
    if (nd >= 3) begin
      chk("held start gap 1", 32'(tms[1] - tms[0]), 32'(W + 2));
      chk("held start gap 2", 32'(tms[2] - tms[1]), 32'(W + 2));
    end
    repeat (W + 3) @(negedge clk);

    // async reset in the middle of a multiply
    run_op(4'd9, 4'd8, OP_ADD, lat, bc);
    check_out("pre-reset add", model(4'd9, 4'd8, OP_ADD), 1, lat, bc);
    @(negedge clk);
    a = 4'd15; b = 4'd15; op_sel = OP_MUL; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre-reset busy", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid-mul reset busy", 32'(busy), 32'd0);
    chk("mid-mul reset done", 32'(done), 32'd0);
    chk("mid-mul reset result", 32'(result), 32'd0);
    chk("mid-mul reset cout", 32'(cout), 32'd0);
    chk("mid-mul reset overflow", 32'(overflow), 32'd0);
    chk("mid-mul reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("aborted mul stays idle", 32'(n_done), 32'd0);
    run_op(4'd5, 4'd6, OP_ADD, lat, bc);
    check_out("post-reset add", model(4'd5, 4'd6, OP_ADD), 1, lat, bc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
